// File: rtl/ual_pkg.sv
// ---------------------------------------------------------------------------
// ual_pkg
//   Definitions shared by the ALU (UAL) and its result stage:
//     - flag bit positions inside the 4-bit {C, Z, N, P} flag vector
//     - width of the packed {M, operatie} op field
//     - the number of flag bits actually stored per FIFO entry
//     - operation codes (74181-style, interpreted together with M)
//
//   Configuration macro: UAL_REZ_PARITY_EN
//     defined   -> the parity flag is stored (4 flag bits per entry)
//     undefined -> the parity flag is tied to 0 (3 flag bits per entry)
// ---------------------------------------------------------------------------
package ual_pkg;

   // Flag positions inside out_flags = {C, Z, N, P}
   localparam int FLAG_W = 4;
   localparam int FLAG_C = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_P = 0;

   // Op field is {M, operatie}
   localparam int OP_CODE_W = 4;
   localparam int OP_W      = 5;

`ifdef UAL_REZ_PARITY_EN
   localparam int FLAG_STORE_W = 4;
`else
   // P is never stored; it is re-inserted as a constant 0 on the way out.
   localparam int FLAG_STORE_W = 3;
`endif

   // Arithmetic-mode operation codes (M = 0)
   localparam logic [OP_CODE_W-1:0] OP_TRANSFER_A   = 4'd0;
   localparam logic [OP_CODE_W-1:0] OP_MINUS_UNU    = 4'd3;
   localparam logic [OP_CODE_W-1:0] OP_SCADERE      = 4'd6;
   localparam logic [OP_CODE_W-1:0] OP_ADUNARE      = 4'd9;
   localparam logic [OP_CODE_W-1:0] OP_DUBLARE      = 4'd12;
   localparam logic [OP_CODE_W-1:0] OP_DECREMENTARE = 4'd15;

   // Logic-mode operation codes (M = 1)
   localparam logic [OP_CODE_W-1:0] OP_NU_A         = 4'd0;
   localparam logic [OP_CODE_W-1:0] OP_XOR          = 4'd6;
   localparam logic [OP_CODE_W-1:0] OP_SI           = 4'd11;
   localparam logic [OP_CODE_W-1:0] OP_SAU          = 4'd14;
   localparam logic [OP_CODE_W-1:0] OP_COPIE_A      = 4'd15;

   // Op field as presented on out_op
   typedef struct packed {
      logic                 m;
      logic [OP_CODE_W-1:0] operatie;
   } ual_op_t;

   function automatic ual_op_t pack_op(input logic m, input logic [OP_CODE_W-1:0] operatie);
      ual_op_t o;
      o.m        = m;
      o.operatie = operatie;
      return o;
   endfunction

endpackage

// File: rtl/ual_fifo.sv
// ---------------------------------------------------------------------------
// ual_fifo
//   Generic synchronous FIFO with registered occupancy. Storage entries reset
//   to zero so the head output is never X, even before the first write.
//
//   Parameters:
//     ENTRY_W  entry width in bits
//     DEPTH    number of entries (power of 2, >= 2)
//
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     push     in   write wr_data (ignored when full)
//     pop      in   drop the head entry (ignored when empty)
//     wr_data  in   ENTRY_W  entry to write
//     rd_data  out  ENTRY_W  head entry
//     count    out  $clog2(DEPTH)+1  occupancy
//     full     out  count == DEPTH
//     empty    out  count == 0
// ---------------------------------------------------------------------------
module ual_fifo #(
   parameter int ENTRY_W = 8,
   parameter int DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [ENTRY_W-1:0]       wr_data,
   output logic [ENTRY_W-1:0]       rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               push_ok;
   logic               pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // DEPTH is a power of 2, so plain AW-bit overflow gives modulo-DEPTH wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;   // idle, or push and pop cancel out
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/ual_registru_rezultat.sv
// ---------------------------------------------------------------------------
// ual_registru_rezultat
//   Result stage behind the 8-bit ALU. Each accepted ALU result is tagged with
//   its {M, operatie} and status flags, buffered in a FIFO and offered to the
//   consumer. Also keeps the last accepted result (acc) and a saturating
//   count of accepted results (nr_op).
//
//   Handshake (both sides): a transfer happens in a cycle where valid and
//   ready are both 1 at the rising edge. A producer holding valid=1 keeps its
//   payload stable until the transfer; ready never depends combinationally on
//   the opposite side (in_ready comes from registered occupancy only).
//
//   Configuration macro: UAL_REZ_PARITY_EN (stores the parity flag P = ^f;
//   without it P reads as 0 and no parity bit is stored).
//
//   Parameters: WIDTH (data width, 8), DEPTH (FIFO entries, power of 2, >= 2)
//
//   Ports:
//     clk, rst_n          clock (rising edge), async active-low reset
//     in_valid/in_ready   upstream handshake
//     f, c_out            ALU result and carry out
//     operatie, M         ALU op code and mode (1 = logic, 0 = arithmetic)
//     out_valid/out_ready downstream handshake
//     out_data            head result
//     out_flags           head flags {C, Z, N, P}
//     out_op              head {M, operatie}
//     acc                 last accepted result
//     nr_op               accepted-result count, saturates at 255
//     count               FIFO occupancy
// ---------------------------------------------------------------------------
module ual_registru_rezultat
   import ual_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        f,
   input  logic                    c_out,
   input  logic [3:0]              operatie,
   input  logic                    M,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [3:0]              out_flags,
   output logic [4:0]              out_op,
   output logic [WIDTH-1:0]        acc,
   output logic [7:0]              nr_op,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int ENTRY_W = OP_W + FLAG_STORE_W + WIDTH;

   // Entry layout, MSB to LSB: {op, stored flags, data}
   localparam int DATA_LSB = 0;
   localparam int FLAG_LSB = WIDTH;
   localparam int OP_LSB   = WIDTH + FLAG_STORE_W;

   logic                    push;
   logic                    pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [ENTRY_W-1:0]      wr_entry;
   logic [ENTRY_W-1:0]      rd_entry;
   logic [FLAG_STORE_W-1:0] wr_flags;
   logic [FLAG_STORE_W-1:0] rd_flags;
   ual_op_t                 wr_op;

   logic                    flag_c;
   logic                    flag_z;
   logic                    flag_n;

   assign in_ready  = !fifo_full;
   assign out_valid = !fifo_empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // ------------------------------------------------------------------
   // Flags from the incoming result. Carry is meaningless for logic ops,
   // so it is masked in logic mode rather than passed through.
   // ------------------------------------------------------------------
   assign flag_c = M ? 1'b0 : c_out;
   assign flag_z = (f == '0);
   assign flag_n = f[WIDTH-1];

`ifdef UAL_REZ_PARITY_EN
   logic flag_p;
   assign flag_p   = ^f;
   assign wr_flags = {flag_c, flag_z, flag_n, flag_p};
`else
   assign wr_flags = {flag_c, flag_z, flag_n};
`endif

   assign wr_op    = pack_op(M, operatie);
   assign wr_entry = {wr_op, wr_flags, f};

   ual_fifo #(
      .ENTRY_W (ENTRY_W),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_entry),
      .rd_data (rd_entry),
      .count   (count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // ------------------------------------------------------------------
   // Head unpacking
   // ------------------------------------------------------------------
   assign out_data = rd_entry[DATA_LSB +: WIDTH];
   assign rd_flags = rd_entry[FLAG_LSB +: FLAG_STORE_W];
   assign out_op   = rd_entry[OP_LSB +: OP_W];

   always_comb begin
      out_flags         = '0;
      out_flags[FLAG_C] = rd_flags[FLAG_STORE_W-1];
      out_flags[FLAG_Z] = rd_flags[FLAG_STORE_W-2];
      out_flags[FLAG_N] = rd_flags[FLAG_STORE_W-3];
`ifdef UAL_REZ_PARITY_EN
      out_flags[FLAG_P] = rd_flags[0];
`endif
   end

   // ------------------------------------------------------------------
   // Debug: last accepted result and saturating accept counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         nr_op <= '0;
      end else if (push) begin
         acc <= f;
         if (nr_op != 8'hFF) nr_op <= nr_op + 8'd1;
      end
   end

endmodule

// File: tb/tb_ual_registru_rezultat.sv
// ---------------------------------------------------------------------------
// tb_ual_registru_rezultat
//   Directed bench for the ALU result stage: a table of single-result
//   vectors with hand-computed flags, then hand-written sequences for
//   backpressure, streaming, counter saturation and reset mid-stream.
// ---------------------------------------------------------------------------
module tb_ual_registru_rezultat;
   import ual_pkg::*;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int CW = $clog2(D) + 1;

`ifdef UAL_REZ_PARITY_EN
   localparam logic [3:0] FLAG_MASK = 4'b1111;
`else
   localparam logic [3:0] FLAG_MASK = 4'b1110;
`endif

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  f;
   logic          c_out;
   logic [3:0]    operatie;
   logic          M;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [3:0]    out_flags;
   logic [4:0]    out_op;
   logic [W-1:0]  acc;
   logic [7:0]    nr_op;
   logic [CW-1:0] count;

   ual_registru_rezultat #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .f         (f),
      .c_out     (c_out),
      .operatie  (operatie),
      .M         (M),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags),
      .out_op    (out_op),
      .acc       (acc),
      .nr_op     (nr_op),
      .count     (count)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int           total = 0;
   int           bad   = 0;
   logic [W-1:0] exp_q[$];
   int           n_push = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_head(input string name);
      if (exp_q.size() == 0) begin
         chk({name, "_queue_empty"}, 32'(out_valid), 32'd0);
      end else begin
         chk(name, 32'(out_data), 32'(exp_q.pop_front()));
      end
   endtask

   // ---------------- drivers ----------------
   // Inputs change 1 time unit after the rising edge; outputs are checked there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic m, input logic [3:0] op, input logic [W-1:0] fv, input logic co);
      in_valid = 1'b1;
      M        = m;
      operatie = op;
      f        = fv;
      c_out    = co;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic         m;
      logic [3:0]   op;
      logic [W-1:0] fv;
      logic         co;
      logic [3:0]   flags;   // {C,Z,N,P} with parity enabled
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{1'b0, OP_ADUNARE,   8'h08, 1'b0, 4'b0001};
      vecs[1] = '{1'b0, OP_MINUS_UNU, 8'h00, 1'b1, 4'b1100};
      vecs[2] = '{1'b1, OP_SI,        8'hFF, 1'b1, 4'b0010};
      vecs[3] = '{1'b1, OP_XOR,       8'h01, 1'b0, 4'b0001};
      vecs[4] = '{1'b0, OP_ADUNARE,   8'h80, 1'b1, 4'b1011};
      vecs[5] = '{1'b0, OP_SCADERE,   8'h7E, 1'b0, 4'b0000};
      vecs[6] = '{1'b1, OP_NU_A,      8'h00, 1'b1, 4'b0100};

      in_valid  = 1'b0;
      out_ready = 1'b0;
      f         = '0;
      c_out     = 1'b0;
      operatie  = '0;
      M         = 1'b0;
      rst_n     = 1'b1;
      #1 rst_n  = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // ---- reset state ----
      chk("rst_count",     32'(count),     32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_flags", 32'(out_flags), 32'd0);
      chk("rst_out_op",    32'(out_op),    32'd0);
      chk("rst_acc",       32'(acc),       32'd0);
      chk("rst_nr_op",     32'(nr_op),     32'd0);

      @(negedge clk) rst_n = 1'b1;
      tick();

      // ---- single-result vectors ----
      for (int i = 0; i < 7; i++) begin
         drive_in(vecs[i].m, vecs[i].op, vecs[i].fv, vecs[i].co);
         out_ready = 1'b1;
         chk($sformatf("v%0d_no_bypass", i), 32'(out_valid), 32'd0);
         tick();
         idle_in();
         n_push++;
         chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("v%0d_data",  i), 32'(out_data),  32'(vecs[i].fv));
         chk($sformatf("v%0d_flags", i), 32'(out_flags), 32'(vecs[i].flags & FLAG_MASK));
         chk($sformatf("v%0d_op",    i), 32'(out_op),    32'({vecs[i].m, vecs[i].op}));
         chk($sformatf("v%0d_acc",   i), 32'(acc),       32'(vecs[i].fv));
         chk($sformatf("v%0d_nr_op", i), 32'(nr_op),     32'(n_push));
         tick();
         chk($sformatf("v%0d_drained", i), 32'(count), 32'd0);
      end
      out_ready = 1'b0;

      // ---- backpressure: fill, hold 0x05, one pop, refill, drain ----
      for (int v = 1; v <= 4; v++) begin
         drive_in(1'b0, OP_ADUNARE, W'(v), 1'b0);
         exp_q.push_back(W'(v));
         tick();
         chk($sformatf("bp_fill_count%0d", v), 32'(count), 32'(v));
      end
      chk("bp_full_in_ready", 32'(in_ready), 32'd0);
      drive_in(1'b0, OP_ADUNARE, 8'h05, 1'b0);
      tick();
      chk("bp_hold_count",    32'(count),    32'd4);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp_head_stable",   32'(out_data), 32'h01);
      out_ready = 1'b1;
      tick();
      void'(exp_q.pop_front());
      chk("bp_pop_count",    32'(count),    32'd3);
      chk("bp_pop_in_ready", 32'(in_ready), 32'd1);
      chk("bp_pop_head",     32'(out_data), 32'h02);
      out_ready = 1'b0;
      tick();
      exp_q.push_back(8'h05);
      idle_in();
      chk("bp_refill_count", 32'(count), 32'd4);
      n_push += 5;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk_head($sformatf("bp_drain%0d", k));
         tick();
      end
      out_ready = 1'b0;
      chk("bp_drain_empty", 32'(count), 32'd0);

      // ---- streaming at count = 2 ----
      drive_in(1'b0, OP_ADUNARE, 8'h10, 1'b0);
      exp_q.push_back(8'h10);
      tick();
      drive_in(1'b0, OP_ADUNARE, 8'h11, 1'b0);
      exp_q.push_back(8'h11);
      tick();
      chk("st_prefill_count", 32'(count), 32'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_in(1'b1, OP_SAU, W'(8'h12 + i), 1'b0);
         chk_head($sformatf("st_head%0d", i));
         exp_q.push_back(W'(8'h12 + i));
         tick();
         chk($sformatf("st_count%0d", i), 32'(count), 32'd2);
      end
      idle_in();
      for (int k = 0; k < 2; k++) begin
         chk_head($sformatf("st_drain%0d", k));
         tick();
      end
      chk("st_empty", 32'(count), 32'd0);
      n_push += 12;
      chk("st_nr_op", 32'(nr_op), 32'(n_push));

      // ---- counter saturation up to 300 accepted results ----
      while (n_push < 300) begin
         drive_in(1'b0, OP_ADUNARE, W'(n_push), 1'b0);
         tick();
         n_push++;
         if (n_push == 254) chk("sat_254", 32'(nr_op), 32'd254);
         if (n_push == 255) chk("sat_255", 32'(nr_op), 32'd255);
         if (n_push == 256) chk("sat_256", 32'(nr_op), 32'd255);
      end
      idle_in();
      chk("sat_300", 32'(nr_op), 32'd255);
      chk("sat_acc", 32'(acc),   32'h2B);
      tick();
      out_ready = 1'b0;
      chk("sat_empty", 32'(count), 32'd0);

      // ---- reset mid-stream with count = 3 ----
      for (int v = 0; v < 3; v++) begin
         drive_in(1'b0, OP_ADUNARE, W'(8'h31 + v), 1'b0);
         tick();
      end
      chk("mr_count3", 32'(count), 32'd3);
      drive_in(1'b0, OP_ADUNARE, 8'h34, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_out_valid", 32'(out_valid), 32'd0);
      chk("mr_count",     32'(count),     32'd0);
      chk("mr_acc",       32'(acc),       32'd0);
      chk("mr_nr_op",     32'(nr_op),     32'd0);
      chk("mr_in_ready",  32'(in_ready),  32'd1);
      chk("mr_out_data",  32'(out_data),  32'd0);
      tick();
      chk("mr_inflight_ignored", 32'(count), 32'd0);
      idle_in();
      exp_q.delete();
      @(negedge clk) rst_n = 1'b1;
      tick();
      drive_in(1'b0, OP_ADUNARE, 8'h2A, 1'b0);
      tick();
      idle_in();
      chk("mr_post_count", 32'(count),    32'd1);
      chk("mr_post_data",  32'(out_data), 32'h2A);
      chk("mr_post_acc",   32'(acc),      32'h2A);
      chk("mr_post_nr_op", 32'(nr_op),    32'd1);
      out_ready = 1'b1;
      tick();
      chk("mr_post_alone", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // ---------------- report ----------------
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
